// File: rtl/ddr3_frame_writer_if.sv
// rtl/ddr3_frame_writer_if.sv - pixel input, status and DDR3 write-port bundle for the frame writer
interface ddr3_frame_writer_if;
  logic         ddr3_init_complete;
  logic         wr_start;
  logic         pix_en;
  logic [31:0]  pix_data;
  logic         pix_ready;
  logic         wr_busy;
  logic         wr_end;
  logic         b0_wr_cmd_clk;
  logic         b0_wr_cmd_en;
  logic [5:0]   b0_wr_cmd_bl;
  logic [27:0]  b0_wr_cmd_byte_addr;
  logic         b0_wr_cmd_empty;
  logic         b0_wr_cmd_full;
  logic         b0_wr_data_clk;
  logic         b0_wr_data_en;
  logic [127:0] b0_wr_data_data;
  logic [15:0]  b0_wr_data_mask;
  logic         b0_wr_data_full;
  logic         b0_wr_data_empty;
  logic [6:0]   b0_wr_data_count;

  modport master (
    input  ddr3_init_complete, wr_start, pix_en, pix_data,
    input  b0_wr_cmd_empty, b0_wr_cmd_full,
    input  b0_wr_data_full, b0_wr_data_empty, b0_wr_data_count,
    output pix_ready, wr_busy, wr_end,
    output b0_wr_cmd_clk, b0_wr_cmd_en, b0_wr_cmd_bl, b0_wr_cmd_byte_addr,
    output b0_wr_data_clk, b0_wr_data_en, b0_wr_data_data, b0_wr_data_mask
  );

  modport slave (
    output ddr3_init_complete, wr_start, pix_en, pix_data,
    output b0_wr_cmd_empty, b0_wr_cmd_full,
    output b0_wr_data_full, b0_wr_data_empty, b0_wr_data_count,
    input  pix_ready, wr_busy, wr_end,
    input  b0_wr_cmd_clk, b0_wr_cmd_en, b0_wr_cmd_bl, b0_wr_cmd_byte_addr,
    input  b0_wr_data_clk, b0_wr_data_en, b0_wr_data_data, b0_wr_data_mask
  );
endinterface

// File: rtl/ddr3_frame_writer.sv
// rtl/ddr3_frame_writer.sv - packs 32-bit pixel beats into 128-bit words and writes a frame in 64-word DDR3 bursts
module ddr3_frame_writer #(
  parameter logic [27:0] BASE_ADDR   = 28'd0,
  parameter int          FRAME_WORDS = 98304
) (
  input logic                 sclk,
  input logic                 rst,
  ddr3_frame_writer_if.master bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, CMD = 2'd2, DRAIN = 2'd3} state_t;

  localparam int              FW          = $clog2(FRAME_WORDS + 1);
  localparam logic [FW-1:0]   FRAME_TOTAL = FW'(FRAME_WORDS);
  localparam logic [FW-1:0]   BURST_WORDS = FW'(64);
  localparam logic [27:0]     BURST_BYTES = 28'd1024;

  state_t         state_q, state_d;
  logic [1:0]     beat_q, beat_d;
  logic [6:0]     burst_q, burst_d;
  logic [FW-1:0]  frame_q, frame_d;
  logic [27:0]    addr_q, addr_d;
  logic [95:0]    pack_q, pack_d;
  logic [127:0]   wdata_q, wdata_d;
  logic           wen_q, wen_d;

  logic start_ok, abort, ready, accept, cmd_fire, drain_go, frame_done;

  assign start_ok   = (state_q == IDLE) && bus.wr_start && bus.ddr3_init_complete;
  assign abort      = (state_q != IDLE) && !bus.ddr3_init_complete;
  assign ready      = (state_q == FILL) && !bus.b0_wr_data_full && (burst_q < 7'd64);
  assign accept     = ready && bus.pix_en && !abort;
  assign cmd_fire   = (state_q == CMD) && !bus.b0_wr_cmd_full && !abort;
  assign drain_go   = (state_q == DRAIN) && bus.b0_wr_data_empty && !abort;
  assign frame_done = (frame_q == FRAME_TOTAL);

  assign bus.b0_wr_cmd_clk  = sclk;
  assign bus.b0_wr_data_clk = sclk;

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      burst_q <= '0;
      frame_q <= '0;
      addr_q  <= '0;
      pack_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      burst_q <= burst_d;
      frame_q <= frame_d;
      addr_q  <= addr_d;
      pack_q  <= pack_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = FILL;
      FILL:    if (wen_q && (burst_q == 7'd64)) state_d = CMD;
      CMD:     if (cmd_fire) state_d = DRAIN;
      DRAIN:   if (drain_go) state_d = frame_done ? IDLE : FILL;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // The fourth beat bypasses pack_q so the full word is registered in the same edge.
  always_comb begin
    beat_d  = beat_q;
    burst_d = burst_q;
    frame_d = frame_q;
    addr_d  = addr_q;
    pack_d  = pack_q;
    wdata_d = wdata_q;
    wen_d   = 1'b0;
    if (start_ok) begin
      addr_d  = BASE_ADDR;
      frame_d = '0;
      burst_d = '0;
      beat_d  = '0;
    end
    if (accept) begin
      case (beat_q)
        2'd0:    pack_d[31:0]  = bus.pix_data;
        2'd1:    pack_d[63:32] = bus.pix_data;
        2'd2:    pack_d[95:64] = bus.pix_data;
        default: begin
          wdata_d = {bus.pix_data, pack_q};
          wen_d   = 1'b1;
          burst_d = burst_q + 7'd1;
        end
      endcase
      beat_d = beat_q + 2'd1;
    end
    if (cmd_fire) begin
      addr_d  = addr_q + BURST_BYTES;
      frame_d = frame_q + BURST_WORDS;
    end
    if (drain_go) burst_d = '0;
    if (abort) begin
      beat_d  = '0;
      burst_d = '0;
    end
  end

  always_comb begin
    bus.pix_ready           = ready;
    bus.wr_busy             = (state_q != IDLE);
    bus.wr_end              = drain_go && frame_done;
    bus.b0_wr_cmd_en        = cmd_fire;
    bus.b0_wr_cmd_bl        = cmd_fire ? 6'd63 : 6'd0;
    bus.b0_wr_cmd_byte_addr = addr_q;
    bus.b0_wr_data_en       = wen_q && bus.ddr3_init_complete;
    bus.b0_wr_data_data     = wdata_q;
    bus.b0_wr_data_mask     = 16'h0000;
  end
endmodule

// File: tb/tb_ddr3_frame_writer.sv
// tb/tb_ddr3_frame_writer.sv - randomized directed bench for ddr3_frame_writer with a handshake-level scoreboard
module tb_ddr3_frame_writer;
  logic sclk = 1'b0;
  always #5 sclk = ~sclk;

  logic        rst, init, wr_start, pix_en, cmd_full, cmd_empty, data_full, data_empty;
  logic [31:0] pix_data;
  logic [6:0]  data_count;

  int n_asserts = 0;
  int n_fail    = 0;

  ddr3_frame_writer_if if0();
  ddr3_frame_writer_if if1();

  assign if0.ddr3_init_complete = init;      assign if1.ddr3_init_complete = init;
  assign if0.wr_start           = wr_start;  assign if1.wr_start           = wr_start;
  assign if0.pix_en             = pix_en;    assign if1.pix_en             = pix_en;
  assign if0.pix_data           = pix_data;  assign if1.pix_data           = pix_data;
  assign if0.b0_wr_cmd_empty    = cmd_empty; assign if1.b0_wr_cmd_empty    = cmd_empty;
  assign if0.b0_wr_cmd_full     = cmd_full;  assign if1.b0_wr_cmd_full     = cmd_full;
  assign if0.b0_wr_data_full    = data_full; assign if1.b0_wr_data_full    = data_full;
  assign if0.b0_wr_data_empty   = data_empty; assign if1.b0_wr_data_empty  = data_empty;
  assign if0.b0_wr_data_count   = data_count; assign if1.b0_wr_data_count  = data_count;

  ddr3_frame_writer #(.BASE_ADDR(28'd0), .FRAME_WORDS(128)) dut0 (
    .sclk(sclk), .rst(rst), .bus(if0.master));
  ddr3_frame_writer #(.BASE_ADDR(28'hFFFFC00), .FRAME_WORDS(128)) dut1 (
    .sclk(sclk), .rst(rst), .bus(if1.master));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: words are rebuilt from the beats seen accepted on the pixel handshake.
  logic [33:0]  cmd0_q[$];
  logic [33:0]  cmd1_q[$];
  int           mb = 0, words0 = 0, end0 = 0, end1 = 0;
  bit           pend = 0, have_first = 0;
  logic [127:0] pack = '0, pend_word = '0, first_word = '0;

  initial begin
    forever begin
      @(negedge sclk);
      if (rst) begin
        mb   = 0;
        pend = 0;
      end else begin
        check("data_en_timing", 128'(if0.b0_wr_data_en), 128'(pend && init));
        if (pend && init) check("data_word", if0.b0_wr_data_data, pend_word);
        if (if0.b0_wr_data_en) begin
          words0++;
          if (!have_first) begin
            first_word = if0.b0_wr_data_data;
            have_first = 1;
          end
        end
        pend = 0;
        if (data_full || !if0.wr_busy) check("ready_gate", 128'(if0.pix_ready), 128'd0);
        if (!init) mb = 0;
        else if (pix_en && if0.pix_ready) begin
          pack[mb*32 +: 32] = pix_data;
          if (mb == 3) begin
            pend      = 1;
            pend_word = pack;
            mb        = 0;
          end else mb++;
        end
        if (if0.b0_wr_cmd_en) cmd0_q.push_back({if0.b0_wr_cmd_bl, if0.b0_wr_cmd_byte_addr});
        if (if1.b0_wr_cmd_en) cmd1_q.push_back({if1.b0_wr_cmd_bl, if1.b0_wr_cmd_byte_addr});
        if (if0.wr_end) end0++;
        if (if1.wr_end) end1++;
      end
    end
  end

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic start();
    wr_start = 1'b1;
    tick();
    wr_start = 1'b0;
  endtask

  task automatic stream(input int n, input bit seq, input int base_val, input int full_pct);
    int sent = 0;
    int budget = 0;
    while (sent < n && budget < 20000) begin
      pix_en     = ($urandom_range(0, 3) != 0);
      pix_data   = seq ? 32'(base_val + sent) : $urandom;
      data_full  = ($urandom_range(0, 99) < full_pct);
      data_empty = ($urandom_range(0, 2) != 0);
      #1;
      if (pix_en && if0.pix_ready) sent++;
      tick();
      budget++;
    end
    pix_en     = 1'b0;
    data_full  = 1'b0;
    data_empty = 1'b1;
    check("stream_beats", 128'(sent), 128'(n));
  endtask

  task automatic wait_idle();
    int b = 0;
    while (if0.wr_busy && b < 3000) begin
      data_empty = ($urandom_range(0, 2) != 0);
      tick();
      b++;
    end
    data_empty = 1'b1;
    check("frame_end_busy", 128'(if0.wr_busy), 128'd0);
  endtask

  task automatic clear_log();
    cmd0_q.delete();
    cmd1_q.delete();
    words0 = 0;
    end0   = 0;
    end1   = 0;
  endtask

  task automatic check_frame();
    logic [33:0] e0[2];
    logic [33:0] e1[2];
    e0[0] = {6'd63, 28'd0};
    e0[1] = {6'd63, 28'd1024};
    e1[0] = {6'd63, 28'hFFFFC00};
    e1[1] = {6'd63, 28'h0000000};
    check("cmd0_count", 128'(cmd0_q.size()), 128'd2);
    check("cmd1_count", 128'(cmd1_q.size()), 128'd2);
    for (int i = 0; i < 2; i++) begin
      if (i < cmd0_q.size()) check("cmd0_bl_addr", 128'(cmd0_q[i]), 128'(e0[i]));
      if (i < cmd1_q.size()) check("cmd1_wrap_addr", 128'(cmd1_q[i]), 128'(e1[i]));
    end
    check("frame_words", 128'(words0), 128'd128);
    check("wr_end0_count", 128'(end0), 128'd1);
    check("wr_end1_count", 128'(end1), 128'd1);
    check("dut1_idle", 128'(if1.wr_busy), 128'd0);
    clear_log();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pix_ready"}, 128'(if0.pix_ready), 128'd0);
    check({tag, "_wr_busy"}, 128'(if0.wr_busy), 128'd0);
    check({tag, "_wr_end"}, 128'(if0.wr_end), 128'd0);
    check({tag, "_cmd_en"}, 128'(if0.b0_wr_cmd_en), 128'd0);
    check({tag, "_data_en"}, 128'(if0.b0_wr_data_en), 128'd0);
    check({tag, "_cmd_bl"}, 128'(if0.b0_wr_cmd_bl), 128'd0);
    check({tag, "_cmd_addr"}, 128'(if0.b0_wr_cmd_byte_addr), 128'd0);
    check({tag, "_data"}, if0.b0_wr_data_data, 128'd0);
    check({tag, "_mask"}, 128'(if0.b0_wr_data_mask), 128'd0);
    check({tag, "_dut1_addr"}, 128'(if1.b0_wr_cmd_byte_addr), 128'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d assertions evaluated", n_asserts);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; init = 1'b1; wr_start = 1'b0; pix_en = 1'b0; pix_data = '0;
    cmd_full = 1'b0; cmd_empty = 1'b1; data_full = 1'b0; data_empty = 1'b1; data_count = '0;
    repeat (3) tick();
    check_reset("reset");
    rst = 1'b0;
    tick();

    // Start ignored while calibration incomplete.
    init = 1'b0;
    start();
    check("noinit_busy0", 128'(if0.wr_busy), 128'd0);
    check("noinit_busy1", 128'(if1.wr_busy), 128'd0);
    init = 1'b1;
    tick();
    check("noinit_still_idle", 128'(if0.wr_busy), 128'd0);

    // Sequential frame 0..511 with a stray start after the first burst.
    start();
    stream(300, 1'b1, 0, 10);
    start();
    stream(212, 1'b1, 300, 10);
    wait_idle();
    check("first_word", first_word, {32'd3, 32'd2, 32'd1, 32'd0});
    check_frame();

    // Command port back-pressure at the end of the first burst.
    cmd_full = 1'b1;
    start();
    stream(256, 1'b0, 0, 0);
    repeat (12) begin
      #1;
      check("cmdfull_no_en", 128'(if0.b0_wr_cmd_en), 128'd0);
      check("cmdfull_addr_hold", 128'(if0.b0_wr_cmd_byte_addr), 128'd0);
      tick();
    end
    check("cmdfull_busy", 128'(if0.wr_busy), 128'd1);
    cmd_full = 1'b0;
    #1;
    check("cmd_release_en", 128'(if0.b0_wr_cmd_en), 128'd1);
    check("cmd_release_bl", 128'(if0.b0_wr_cmd_bl), 128'd63);
    check("cmd_release_addr", 128'(if0.b0_wr_cmd_byte_addr), 128'd0);
    tick();
    check("cmd_single_pulse", 128'(if0.b0_wr_cmd_en), 128'd0);
    check("addr_advanced", 128'(if0.b0_wr_cmd_byte_addr), 128'd1024);
    stream(256, 1'b0, 0, 10);
    wait_idle();
    check_frame();

    // Reset after 100 beats, then a clean frame from BASE_ADDR.
    start();
    stream(100, 1'b0, 0, 10);
    rst = 1'b1;
    tick();
    check_reset("midrst");
    rst = 1'b0;
    check("midrst_no_cmd0", 128'(cmd0_q.size()), 128'd0);
    check("midrst_no_cmd1", 128'(cmd1_q.size()), 128'd0);
    clear_log();
    tick();
    start();
    stream(512, 1'b0, 0, 10);
    wait_idle();
    check_frame();

    // Calibration lost in the second burst.
    start();
    stream(301, 1'b0, 0, 10);
    init = 1'b0;
    tick();
    check("abort_busy", 128'(if0.wr_busy), 128'd0);
    check("abort_cmd_en", 128'(if0.b0_wr_cmd_en), 128'd0);
    check("abort_data_en", 128'(if0.b0_wr_data_en), 128'd0);
    init = 1'b1;
    check("abort_cmd_count", 128'(cmd0_q.size()), 128'd1);
    if (cmd0_q.size() > 0) check("abort_cmd0", 128'(cmd0_q[0]), 128'({6'd63, 28'd0}));
    if (cmd1_q.size() > 0) check("abort_cmd1", 128'(cmd1_q[0]), 128'({6'd63, 28'hFFFFC00}));
    check("abort_no_wr_end", 128'(end0), 128'd0);
    clear_log();
    tick();
    start();
    stream(512, 1'b0, 0, 10);
    wait_idle();
    check_frame();

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
